// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit: state encoding and the PC legality check.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // A PC is fetchable when word aligned and inside the instruction memory.
  function automatic logic pc_legal(input logic [XLEN-1:0] pc, input int unsigned depth);
    logic [XLEN-1:0] limit;
    limit = XLEN'(depth) << 2;
    return (pc[1:0] == 2'b00) && (pc < limit);
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Handshake and stall event counters for the fetch unit; free-running, wrap at 2^32, frozen when en=0.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        accept,
  input  logic        stall,
  output logic [31:0] fetched,
  output logic [31:0] stalls
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched <= 32'd0;
      stalls  <= 32'd0;
    end else if (en) begin
      if (accept) fetched <= fetched + 32'd1;
      if (stall)  stalls  <= stalls + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single output slot to decode, redirect and fault halt.
// Optional macro FETCH_PERF_EN adds perf_fetched_o / perf_stall_o event counters.
module instr_fetch_unit #(
  parameter int                  XLEN       = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]     RESET_PC   = '0,
  parameter int unsigned         IMEM_DEPTH = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_stall_o
`endif
);

  import fetch_pkg::*;

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            slot_free;
  logic            pc_ok;
  logic            redirect_ok;

  assign imem_addr_o = pc_q;
  assign accept      = valid_o & ready_i;
  assign slot_free   = ~valid_o | ready_i;
  assign pc_ok       = pc_legal(pc_q, IMEM_DEPTH);
  assign redirect_ok = pc_legal(redirect_pc_i, IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      valid_o    <= 1'b0;
      inst_o     <= '0;
      inst_pc_o  <= '0;
      fault_o    <= 1'b0;
      fault_pc_o <= '0;
    end else if (redirect_i) begin
      // Redirect flushes the slot; an accept in this same cycle was already consumed by decode.
      valid_o <= 1'b0;
      pc_q    <= redirect_pc_i;
      if (!redirect_ok) begin
        state_q    <= FAULT;
        fault_o    <= 1'b1;
        fault_pc_o <= redirect_pc_i;
      end else begin
        state_q <= run_i ? RUN : IDLE;
        fault_o <= 1'b0;
      end
    end else begin
      if (accept) valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_i) state_q <= RUN;
        end
        RUN: begin
          if (!run_i) begin
            state_q <= IDLE;
          end else if (slot_free) begin
            // The fault is only raised when a fetch would actually issue.
            if (pc_ok) begin
              inst_o    <= imem_rdata_i;
              inst_pc_o <= pc_q;
              valid_o   <= 1'b1;
              pc_q      <= pc_q + XLEN'(4);
            end else begin
              state_q    <= FAULT;
              fault_o    <= 1'b1;
              fault_pc_o <= pc_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != FAULT),
    .accept  (accept),
    .stall   (valid_o & ~ready_i),
    .fetched (perf_fetched_o),
    .stalls  (perf_stall_o)
  );
`endif

endmodule
